// File: rtl/conv_pkg.sv
// Shared constants, FSM state type and saturation helper for the 3x3 convolution core.
package conv_pkg;
   localparam int IFM_W     = 58;
   localparam int OFM_W     = IFM_W - 2;
   localparam int CH_IN     = 16;
   localparam int GROUPS    = CH_IN / 4;
   localparam int NUM_PE    = 16;
   localparam int NUM_PASS  = 2;
   localparam int TAPS      = 9 * GROUPS;
   localparam int W_WORDS   = NUM_PASS * TAPS;
   // Depths cover the full 14-bit / 7-bit address fields so the index width matches.
   localparam int IFM_DEPTH = 16384;
   localparam int W_DEPTH   = 128;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic [7:0] sat8(input logic signed [31:0] v);
      logic [7:0] r;
      if (v > 32'sd127) begin
         r = 8'h7f;
      end else if (v < -32'sd128) begin
         r = 8'h80;
      end else begin
         r = v[7:0];
      end
      return r;
   endfunction
endpackage

// File: rtl/conv_pe.sv
// One processing element: 4-lane signed int8 MAC, 32-bit accumulator,
// shift/saturate and registered int8 output.
module conv_pe #(
   parameter int OUT_SHIFT = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        acc_en,
   input  logic        first,
   input  logic        last,
   input  logic [31:0] ifm_word,
   input  logic [31:0] w_word,
   output logic [7:0]  ofm,
   output logic        finish
);
   import conv_pkg::*;

   logic signed [7:0]  a_s [4];
   logic signed [7:0]  b_s [4];
   logic signed [15:0] m_s [4];
   logic signed [31:0] prod_sum;
   logic signed [31:0] acc;
   logic signed [31:0] shifted;

   // Lane 0 is the most significant byte (lowest channel of the group).
   always_comb begin
      prod_sum = 32'sd0;
      for (int j = 0; j < 4; j++) begin
         a_s[j]   = ifm_word[31-8*j -: 8];
         b_s[j]   = w_word[31-8*j -: 8];
         m_s[j]   = a_s[j] * b_s[j];
         prod_sum = prod_sum + {{16{m_s[j][15]}}, m_s[j]};
      end
      shifted = acc >>> OUT_SHIFT;
   end

   // Accumulator restarts on the first word of each pixel; disabled PE holds.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc <= 32'sd0;
      end else if (acc_en && en) begin
         acc <= first ? prod_sum : acc + prod_sum;
      end
   end

   // Output register and finish pulse, loaded one cycle after the last MAC.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ofm    <= 8'd0;
         finish <= 1'b0;
      end else begin
         finish <= last & en;
         if (last && en) begin
            ofm <= sat8(shifted);
         end
      end
   end
endmodule

// File: rtl/sub_top_conv_core.sv
// 3x3 convolution core: IFM and weight memories, address generator, run FSM
// and NUM_PE MAC elements. Pipeline is address -> read data -> MAC -> output.
module sub_top_conv_core #(
   parameter int IFM_W     = conv_pkg::IFM_W,
   parameter int OUT_SHIFT = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        we_IFM,
   input  logic        we_weight,
   input  logic [31:0] addr,
   input  logic [31:0] data_in_IFM,
   input  logic [31:0] data_in_Weight_0,  input logic [31:0] data_in_Weight_1,
   input  logic [31:0] data_in_Weight_2,  input logic [31:0] data_in_Weight_3,
   input  logic [31:0] data_in_Weight_4,  input logic [31:0] data_in_Weight_5,
   input  logic [31:0] data_in_Weight_6,  input logic [31:0] data_in_Weight_7,
   input  logic [31:0] data_in_Weight_8,  input logic [31:0] data_in_Weight_9,
   input  logic [31:0] data_in_Weight_10, input logic [31:0] data_in_Weight_11,
   input  logic [31:0] data_in_Weight_12, input logic [31:0] data_in_Weight_13,
   input  logic [31:0] data_in_Weight_14, input logic [31:0] data_in_Weight_15,
   input  logic        cal_start,
   input  logic [15:0] PE_en,
   output logic [15:0] PE_finish,
   output logic        valid,
   output logic [31:0] OFM,
   output logic [7:0]  OFM_0,  output logic [7:0] OFM_1,  output logic [7:0] OFM_2,
   output logic [7:0]  OFM_3,  output logic [7:0] OFM_4,  output logic [7:0] OFM_5,
   output logic [7:0]  OFM_6,  output logic [7:0] OFM_7,  output logic [7:0] OFM_8,
   output logic [7:0]  OFM_9,  output logic [7:0] OFM_10, output logic [7:0] OFM_11,
   output logic [7:0]  OFM_12, output logic [7:0] OFM_13, output logic [7:0] OFM_14,
   output logic [7:0]  OFM_15
);
   import conv_pkg::*;

   localparam int OW = IFM_W - 2;

   state_t      state;
   logic [0:0]  p;
   logic [7:0]  r, c;
   logic [1:0]  kr, kc, g;
   logic        first_word, last_word, last_pixel, wr_ok;
   logic [13:0] ifm_raddr;
   logic [6:0]  w_raddr;
   logic        s1_valid, s1_first, s1_last, s2_last;
   logic [31:0] ifm_mem [IFM_DEPTH];
   logic [31:0] w_mem [NUM_PE][W_DEPTH];
   logic [31:0] ifm_rd;
   logic [31:0] w_rd [NUM_PE];
   logic [31:0] wdata [NUM_PE];
   logic [7:0]  ofm_s [NUM_PE];
   logic [17:0] unused_addr;

   assign unused_addr = addr[31:14];
   assign wdata = '{data_in_Weight_0, data_in_Weight_1, data_in_Weight_2, data_in_Weight_3,
                    data_in_Weight_4, data_in_Weight_5, data_in_Weight_6, data_in_Weight_7,
                    data_in_Weight_8, data_in_Weight_9, data_in_Weight_10, data_in_Weight_11,
                    data_in_Weight_12, data_in_Weight_13, data_in_Weight_14, data_in_Weight_15};

   assign first_word = (kr == 2'd0) && (kc == 2'd0) && (g == 2'd0);
   assign last_word  = (kr == 2'd2) && (kc == 2'd2) && (g == 2'd3);
   assign last_pixel = (c == 8'(OW - 1)) && (r == 8'(OW - 1));
   assign wr_ok      = (state != RUN);
   assign ifm_raddr  = 14'(((32'(r) + 32'(kr)) * 32'(IFM_W) + 32'(c) + 32'(kc)) * 32'd4 + 32'(g));
   assign w_raddr    = 7'(32'(p) * 32'(TAPS) + (32'(kr) * 32'd3 + 32'(kc)) * 32'd4 + 32'(g));

   // Memory writes (blocked while running) and synchronous 1-cycle reads.
   always_ff @(posedge clk) begin
      if (we_IFM && wr_ok) begin
         ifm_mem[addr[13:0]] <= data_in_IFM;
      end
      ifm_rd <= ifm_mem[ifm_raddr];
      for (int k = 0; k < NUM_PE; k++) begin
         if (we_weight && wr_ok) begin
            w_mem[k][addr[6:0]] <= wdata[k];
         end
         w_rd[k] <= w_mem[k][w_raddr];
      end
   end

   // Run FSM and loop counters: p, r, c, kr, kc, g from outer to inner.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         p <= 1'b0; r <= 8'd0; c <= 8'd0; kr <= 2'd0; kc <= 2'd0; g <= 2'd0;
      end else begin
         case (state)
            IDLE: begin
               if (cal_start) begin
                  state <= RUN;
                  p <= 1'b0; r <= 8'd0; c <= 8'd0; kr <= 2'd0; kc <= 2'd0; g <= 2'd0;
               end
            end
            RUN: begin
               g <= g + 2'd1;
               if (g == 2'd3) begin
                  kc <= (kc == 2'd2) ? 2'd0 : kc + 2'd1;
                  if (kc == 2'd2) begin
                     kr <= (kr == 2'd2) ? 2'd0 : kr + 2'd1;
                     if (kr == 2'd2) begin
                        c <= (c == 8'(OW - 1)) ? 8'd0 : c + 8'd1;
                        if (c == 8'(OW - 1)) begin
                           r <= (r == 8'(OW - 1)) ? 8'd0 : r + 8'd1;
                        end
                        if (last_pixel) begin
                           p <= p + 1'b1;
                           if (p == 1'b1) begin
                              state <= DONE;
                           end
                        end
                     end
                  end
               end
            end
            DONE: begin
               if (!cal_start) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Control pipeline aligned with read data (s1) and the accumulator (s2).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_valid <= 1'b0; s1_first <= 1'b0; s1_last <= 1'b0; s2_last <= 1'b0; valid <= 1'b0;
      end else begin
         s1_valid <= (state == RUN);
         s1_first <= (state == RUN) && first_word;
         s1_last  <= (state == RUN) && last_word;
         s2_last  <= s1_last;
         valid    <= s2_last;
      end
   end

   for (genvar i = 0; i < NUM_PE; i++) begin : g_pe
      conv_pe #(.OUT_SHIFT(OUT_SHIFT)) u_pe (
         .clk(clk), .reset(reset), .en(PE_en[i]), .acc_en(s1_valid), .first(s1_first),
         .last(s2_last), .ifm_word(ifm_rd), .w_word(w_rd[i]), .ofm(ofm_s[i]),
         .finish(PE_finish[i])
      );
   end

   assign OFM_0  = ofm_s[0];  assign OFM_1  = ofm_s[1];  assign OFM_2  = ofm_s[2];
   assign OFM_3  = ofm_s[3];  assign OFM_4  = ofm_s[4];  assign OFM_5  = ofm_s[5];
   assign OFM_6  = ofm_s[6];  assign OFM_7  = ofm_s[7];  assign OFM_8  = ofm_s[8];
   assign OFM_9  = ofm_s[9];  assign OFM_10 = ofm_s[10]; assign OFM_11 = ofm_s[11];
   assign OFM_12 = ofm_s[12]; assign OFM_13 = ofm_s[13]; assign OFM_14 = ofm_s[14];
   assign OFM_15 = ofm_s[15];
   assign OFM    = {ofm_s[0], ofm_s[1], ofm_s[2], ofm_s[3]};
endmodule

// File: tb/tb_sub_top_conv_core.sv
// Directed bench for sub_top_conv_core on a reduced 5x5 padded image (3x3 output),
// OUT_SHIFT=1; table of data patterns plus reset-abort and hold-start sequences.
module tb_sub_top_conv_core;
   localparam int IW   = 5;
   localparam int OW   = IW - 2;
   localparam int NPIX = 2 * OW * OW;
   localparam int SH   = 1;

   typedef struct {
      int         mode;     // 0 uniform, 1 single PE3 tap, 2 position pattern
      logic [7:0] ifm_b;
      logic [7:0] w_b;
      logic [15:0] en;
      logic [7:0] exp;      // hand-computed result for mode 0, enabled PEs
      bit         disturb;  // attempt an IFM write mid-run
   } vec_t;

   logic        clk = 1'b0;
   logic        reset, we_IFM, we_weight, cal_start, valid;
   logic [31:0] addr, data_in_IFM, ofm_bus;
   logic [31:0] wdat [16];
   logic [15:0] pe_en, pe_fin;
   logic [7:0]  ofm [16];
   int          errors = 0;
   int          checks = 0;
   vec_t        vecs [9];

   always #5 clk = ~clk;

   sub_top_conv_core #(.IFM_W(IW), .OUT_SHIFT(SH)) dut (
      .clk(clk), .reset(reset), .we_IFM(we_IFM), .we_weight(we_weight), .addr(addr),
      .data_in_IFM(data_in_IFM),
      .data_in_Weight_0(wdat[0]), .data_in_Weight_1(wdat[1]), .data_in_Weight_2(wdat[2]),
      .data_in_Weight_3(wdat[3]), .data_in_Weight_4(wdat[4]), .data_in_Weight_5(wdat[5]),
      .data_in_Weight_6(wdat[6]), .data_in_Weight_7(wdat[7]), .data_in_Weight_8(wdat[8]),
      .data_in_Weight_9(wdat[9]), .data_in_Weight_10(wdat[10]), .data_in_Weight_11(wdat[11]),
      .data_in_Weight_12(wdat[12]), .data_in_Weight_13(wdat[13]), .data_in_Weight_14(wdat[14]),
      .data_in_Weight_15(wdat[15]),
      .cal_start(cal_start), .PE_en(pe_en), .PE_finish(pe_fin), .valid(valid), .OFM(ofm_bus),
      .OFM_0(ofm[0]), .OFM_1(ofm[1]), .OFM_2(ofm[2]), .OFM_3(ofm[3]), .OFM_4(ofm[4]),
      .OFM_5(ofm[5]), .OFM_6(ofm[6]), .OFM_7(ofm[7]), .OFM_8(ofm[8]), .OFM_9(ofm[9]),
      .OFM_10(ofm[10]), .OFM_11(ofm[11]), .OFM_12(ofm[12]), .OFM_13(ofm[13]),
      .OFM_14(ofm[14]), .OFM_15(ofm[15])
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] bsat(input int v);
      if (v > 127) return 8'h7f;
      else if (v < -128) return 8'h80;
      else return 8'(v);
   endfunction

   function automatic logic [7:0] model(input vec_t v, input int pe, input int pass,
                                        input int r, input int c);
      int acc;
      if (!v.en[pe]) return 8'h00;
      if (v.mode == 0) return v.exp;
      if (v.mode == 1) return (pe == 3 && pass == 0) ? 8'hff : 8'h00;
      acc = 0;
      if (pe == 0) acc = ((pass == 0) ? 2 : 4) * ((r + 1) * IW + c + 1);
      if (pe == 1 && pass == 0) acc = 2 * (100 - ((r + 2) * IW + c));
      return bsat(acc >>> SH);
   endfunction

   task automatic do_reset();
      cal_start = 1'b0;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic load(input vec_t v);
      logic [31:0] w;
      for (int i = 0; i < IW * IW * 4; i++) begin
         @(negedge clk);
         we_IFM = 1'b1; addr = i;
         if (v.mode == 2)
            data_in_IFM = (i % 4 == 0) ? {8'(i / 4), 24'h0} :
                          (i % 4 == 3) ? {24'h0, 8'(100 - i / 4)} : 32'h0;
         else
            data_in_IFM = {4{v.ifm_b}};
      end
      @(negedge clk);
      we_IFM = 1'b0;
      for (int i = 0; i < 72; i++) begin
         @(negedge clk);
         we_weight = 1'b1; addr = i;
         for (int k = 0; k < 16; k++) begin
            w = 32'h0;
            if (v.mode == 0) w = {4{v.w_b}};
            if (v.mode == 1 && k == 3 && i == 0) w = 32'hff000000;
            if (v.mode == 2 && k == 0 && i == 16) w = 32'h02000000;
            if (v.mode == 2 && k == 0 && i == 52) w = 32'h04000000;
            if (v.mode == 2 && k == 1 && i == 27) w = 32'h00000002;
            wdat[k] = w;
         end
      end
      @(negedge clk);
      we_weight = 1'b0;
   endtask

   // Start a run and check every pixel, its timing, and that a held start does not retrigger.
   task automatic run(input vec_t v, input string tag);
      int cyc, prev, extra, pass, r, c;
      bit got;
      pe_en = v.en;
      @(posedge clk); #1;
      cal_start = 1'b1;
      cyc = 0; prev = 0;
      for (int k = 0; k < NPIX; k++) begin
         got = 1'b0;
         for (int b = 0; b < 200 && !got; b++) begin
            @(posedge clk); #1;
            cyc++;
            if (v.disturb && cyc == 100) begin
               we_IFM = 1'b1; addr = 32'd0; data_in_IFM = 32'h7f7f7f7f;
            end else begin
               we_IFM = 1'b0;
            end
            if (valid) got = 1'b1;
         end
         if (!got) begin
            checks++; errors++;
            $display("FAIL %s timeout: pixel %0d never became valid", tag, k);
            cal_start = 1'b0; we_IFM = 1'b0;
            return;
         end
         check({tag, " latency"}, cyc - prev, (k == 0) ? 39 : 36);
         prev = cyc;
         pass = k / (OW * OW); r = (k % (OW * OW)) / OW; c = k % OW;
         for (int pe = 0; pe < 16; pe++)
            check($sformatf("%s pix%0d ofm%0d", tag, k, pe), ofm[pe], model(v, pe, pass, r, c));
         check({tag, " PE_finish"}, pe_fin, v.en);
         check({tag, " OFM bus"}, ofm_bus, {ofm[0], ofm[1], ofm[2], ofm[3]});
      end
      we_IFM = 1'b0;
      extra = 0;
      repeat (80) begin
         @(posedge clk); #1;
         if (valid) extra++;
      end
      check({tag, " no retrigger"}, extra, 0);
      cal_start = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   initial begin
      vec_t vr;
      vecs[0] = '{0, 8'h01, 8'h01, 16'hffff, 8'h48, 1'b0};
      vecs[1] = '{0, 8'h01, 8'h02, 16'hffff, 8'h7f, 1'b0};
      vecs[2] = '{0, 8'h01, 8'hfe, 16'hffff, 8'h80, 1'b0};
      vecs[3] = '{0, 8'hff, 8'hff, 16'hffff, 8'h48, 1'b0};
      vecs[4] = '{0, 8'h80, 8'h80, 16'hffff, 8'h7f, 1'b0};
      vecs[5] = '{0, 8'h01, 8'h01, 16'h0001, 8'h48, 1'b0};
      vecs[6] = '{1, 8'h01, 8'h00, 16'hffff, 8'h00, 1'b0};
      vecs[7] = '{2, 8'h00, 8'h00, 16'hffff, 8'h00, 1'b0};
      vecs[8] = '{0, 8'h01, 8'h01, 16'hffff, 8'h48, 1'b1};
      we_IFM = 1'b0; we_weight = 1'b0; addr = 32'h0; data_in_IFM = 32'h0;
      pe_en = 16'hffff;
      for (int k = 0; k < 16; k++) wdat[k] = 32'h0;
      do_reset();
      #1;
      check("reset valid", valid, 1'b0);
      check("reset OFM", ofm_bus, 32'h0);
      check("reset PE_finish", pe_fin, 16'h0);
      check("reset OFM_15", ofm[15], 8'h0);

      for (int i = 0; i < 9; i++) begin
         do_reset();
         load(vecs[i]);
         run(vecs[i], $sformatf("vec%0d", i));
      end

      // Asynchronous reset in the middle of a run, then a clean restart.
      do_reset();
      load(vecs[0]);
      pe_en = 16'hffff;
      @(posedge clk); #1;
      cal_start = 1'b1;
      repeat (1000) @(posedge clk);
      #3;
      check("pre-abort OFM_0", ofm[0], 8'h48);
      reset = 1'b0;
      #1;
      check("abort OFM_0", ofm[0], 8'h0);
      check("abort OFM bus", ofm_bus, 32'h0);
      check("abort valid", valid, 1'b0);
      check("abort PE_finish", pe_fin, 16'h0);
      cal_start = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      vr = vecs[7];
      load(vr);
      run(vr, "restart");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
